multiword_add_seq: RTL and testbench

- Sequencer that performs wide two's-complement add/subtract by time-multiplexing one 12-bit add slice: A+B+Cin -> {Co,S}.
- Processes one 12-bit limb per clock, LSB limb first, and chains the carry through a register.
- Sits between a requesting controller (start/done handshake) and the arithmetic datapath, replacing a wide combinational adder with a single narrow one.

---
 rtl/multiword_add_seq.sv | 127 ++++++++++++
 tb/tb_multiword_add_seq.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/multiword_add_seq.sv
// multiword_add_seq: wide two's-complement add/subtract built from one 12-bit
// add slice, stepped once per clock from the least significant limb upward with
// the carry held in a register between limbs.
module multiword_add_seq #(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [12*WORDS-1:0]   a,
  input  logic [12*WORDS-1:0]   b,
  output logic                  busy,
  output logic                  done,
  output logic [12*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf
);

  localparam int LIMB  = 12;
  localparam int W     = LIMB * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_next;
  logic [W-1:0]     opa;
  logic [W-1:0]     opb;
  logic [W-1:0]     acc;
  logic [W-1:0]     acc_merged;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [LIMB-1:0]  limb_a;
  logic [LIMB-1:0]  limb_b;
  logic [LIMB-1:0]  limb_s;
  logic             limb_co;
  logic             last_limb;

  // The single narrow adder slice: {co, s} = x + y + ci.
  function automatic logic [LIMB:0] limb_add(input logic [LIMB-1:0] x,
                                             input logic [LIMB-1:0] y,
                                             input logic            ci);
    return {1'b0, x} + {1'b0, y} + {{LIMB{1'b0}}, ci};
  endfunction

  // Signed overflow: operands agree in sign but the result sign differs.
  function automatic logic signed_ovf(input logic msb_a,
                                      input logic msb_b,
                                      input logic msb_s);
    return (msb_a == msb_b) && (msb_s != msb_a);
  endfunction

  // Select the current limb, add it, and merge the result into the accumulator.
  always_comb begin
    limb_a                       = opa[idx*LIMB +: LIMB];
    limb_b                       = opb[idx*LIMB +: LIMB];
    {limb_co, limb_s}            = limb_add(limb_a, limb_b, carry);
    acc_merged                   = acc;
    acc_merged[idx*LIMB +: LIMB] = limb_s;
  end

  assign last_limb = (idx == LAST);

  // busy rises once the first limb has been consumed and drops with done.
  assign busy = (state == RUN) && (idx != '0);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next state: accept a request in IDLE, return after the top limb.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_limb) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, limb stepping, and result publication on completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa   <= '0;
      opb   <= '0;
      acc   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert B once here, seed carry with 1.
            opa   <= a;
            opb   <= b ^ {W{sub}};
            carry <= sub;
            idx   <= '0;
          end
        end
        RUN: begin
          acc   <= acc_merged;
          carry <= limb_co;
          if (last_limb) begin
            idx  <= '0;
            sum  <= acc_merged;
            cout <= limb_co;
            ovf  <= signed_ovf(opa[W-1], opb[W-1], limb_s[LIMB-1]);
            done <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed bench for multiword_add_seq at WORDS=4 (48-bit operands).
module tb_multiword_add_seq;

  localparam int W = 48;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         sub;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int n_tests = 0;
  int n_fail  = 0;

  multiword_add_seq #(.WORDS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .sub   (sub),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive a request and let the start edge pass; afterwards scribble on the
  // operand inputs, which must have no effect on the running operation.
  task automatic issue(input logic [W-1:0] va, input logic [W-1:0] vb, input logic vs);
    @(negedge clk);
    a = va; b = vb; sub = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 48'h5A5A_5A5A_5A5A; b = 48'hA5A5_A5A5_A5A5; sub = ~vs;
  endtask

  // Step cycles until done (bounded), counting cycles and busy cycles seen.
  task automatic wait_done(output int cycles, output int busy_cnt, output bit seen);
    cycles = 0; busy_cnt = 0; seen = 1'b0;
    while (!seen && cycles < 20) begin
      @(posedge clk); #1;
      cycles++;
      if (done) seen = 1'b1;
      else if (busy) busy_cnt++;
    end
  endtask

  task automatic test_reset;
    #2;
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_tests++; if (sum !== 48'h0) begin n_fail++; $display("FAIL reset_sum got=%h exp=0", sum); end
    n_tests++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL reset_flags got=%b exp=00", {cout, ovf}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%b done=%b exp=0,0", busy, done); end
  endtask

  task automatic test_carry_chain;
    int cyc, bc; bit seen;
    issue(48'h0000_0000_0FFF, 48'h0000_0000_0001, 1'b0);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL carry_busy_first got=%b exp=0", busy); end
    wait_done(cyc, bc, seen);
    n_tests++; if (!seen || cyc != 4) begin n_fail++; $display("FAIL carry_latency seen=%0d got=%0d exp=4", seen, cyc); end
    n_tests++; if (bc != 3) begin n_fail++; $display("FAIL carry_busy_cycles got=%0d exp=3", bc); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL carry_busy_done got=%b exp=0", busy); end
    n_tests++; if (sum !== 48'h0000_0000_1000) begin n_fail++; $display("FAIL carry_sum got=%h exp=000000001000", sum); end
    n_tests++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL carry_flags got=%b exp=00", {cout, ovf}); end
    @(posedge clk); #1;
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL carry_done_width got=%b exp=0", done); end
    n_tests++; if (sum !== 48'h0000_0000_1000) begin n_fail++; $display("FAIL carry_sum_hold got=%h exp=000000001000", sum); end
  endtask

  task automatic test_ripple;
    int cyc, bc; bit seen;
    issue(48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0);
    wait_done(cyc, bc, seen);
    n_tests++; if (!seen || cyc != 4) begin n_fail++; $display("FAIL ripple_latency seen=%0d got=%0d exp=4", seen, cyc); end
    n_tests++; if (sum !== 48'h0) begin n_fail++; $display("FAIL ripple_sum got=%h exp=000000000000", sum); end
    n_tests++; if ({cout, ovf} !== 2'b10) begin n_fail++; $display("FAIL ripple_flags got=%b exp=10", {cout, ovf}); end
  endtask

  task automatic test_overflow;
    int cyc, bc; bit seen;
    issue(48'h7FFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0);
    wait_done(cyc, bc, seen);
    n_tests++; if (!seen) begin n_fail++; $display("FAIL ovf_timeout got=0 exp=1"); end
    n_tests++; if (sum !== 48'h8000_0000_0000) begin n_fail++; $display("FAIL ovf_sum got=%h exp=800000000000", sum); end
    n_tests++; if ({cout, ovf} !== 2'b01) begin n_fail++; $display("FAIL ovf_flags got=%b exp=01", {cout, ovf}); end
  endtask

  task automatic test_back_to_back;
    int cyc, bc; bit seen;
    issue(48'h5, 48'h7, 1'b1);
    wait_done(cyc, bc, seen);
    n_tests++; if (!seen || cyc != 4) begin n_fail++; $display("FAIL sub1_latency seen=%0d got=%0d exp=4", seen, cyc); end
    n_tests++; if (sum !== 48'hFFFF_FFFF_FFFE) begin n_fail++; $display("FAIL sub1_sum got=%h exp=fffffffffffe", sum); end
    n_tests++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL sub1_flags got=%b exp=00", {cout, ovf}); end
    // Still inside the done cycle: request the next operation right away.
    a = 48'h7; b = 48'h5; sub = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 48'h0; b = 48'h0; sub = 1'b0;
    n_tests++; if (sum !== 48'hFFFF_FFFF_FFFE) begin n_fail++; $display("FAIL sub_hold_sum got=%h exp=fffffffffffe", sum); end
    wait_done(cyc, bc, seen);
    n_tests++; if (!seen || cyc != 4) begin n_fail++; $display("FAIL sub2_latency seen=%0d got=%0d exp=4", seen, cyc); end
    n_tests++; if (sum !== 48'h0000_0000_0002) begin n_fail++; $display("FAIL sub2_sum got=%h exp=000000000002", sum); end
    n_tests++; if ({cout, ovf} !== 2'b10) begin n_fail++; $display("FAIL sub2_flags got=%b exp=10", {cout, ovf}); end
  endtask

  task automatic test_start_while_busy;
    int dones, first_at;
    logic [W-1:0] got;
    issue(48'h1, 48'h2, 1'b0);
    @(negedge clk);
    a = 48'h100; b = 48'h100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = (done === 1'b1) ? 1 : 0;
    first_at = 1; got = sum;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        if (dones == 0) begin first_at = i; got = sum; end
        dones++;
      end
    end
    n_tests++; if (dones != 1) begin n_fail++; $display("FAIL busy_start_dones got=%0d exp=1", dones); end
    n_tests++; if (first_at != 4) begin n_fail++; $display("FAIL busy_start_latency got=%0d exp=4", first_at); end
    n_tests++; if (got !== 48'h3) begin n_fail++; $display("FAIL busy_start_sum got=%h exp=000000000003", got); end
  endtask

  task automatic test_mid_reset;
    int cyc, bc, dones; bit seen;
    issue(48'h123, 48'h456, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before got=%b exp=1", busy); end
    @(negedge clk); rst_n = 1'b0; #1;
    n_tests++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_ctrl busy=%b done=%b exp=0,0", busy, done); end
    n_tests++; if (sum !== 48'h0) begin n_fail++; $display("FAIL midrst_sum got=%h exp=0", sum); end
    n_tests++; if ({cout, ovf} !== 2'b00) begin n_fail++; $display("FAIL midrst_flags got=%b exp=00", {cout, ovf}); end
    @(negedge clk); rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1) dones++;
    end
    n_tests++; if (dones != 0) begin n_fail++; $display("FAIL midrst_no_done got=%0d exp=0", dones); end
    issue(48'h2, 48'h3, 1'b0);
    wait_done(cyc, bc, seen);
    n_tests++; if (!seen || cyc != 4) begin n_fail++; $display("FAIL midrst_next_latency seen=%0d got=%0d exp=4", seen, cyc); end
    n_tests++; if (sum !== 48'h5) begin n_fail++; $display("FAIL midrst_next_sum got=%h exp=000000000005", sum); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; sub = 1'b0;
    a = 48'h1234_5678_9ABC; b = 48'h0FED_CBA9_8765;
    test_reset();
    test_carry_chain();
    test_ripple();
    test_overflow();
    test_back_to_back();
    test_start_while_busy();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
